// File: rtl/vx_wb_pkg.sv
// vx_wb_pkg -- shared definitions for the writeback arbiter slice.
//   ARB_FIXED / ARB_RR : arbitration mode selectors for ARB_MODE.
//   VX_*               : default payload geometry (threads, warp-id, reg-index).
//   wb_payload_t       : one writeback payload in the default geometry.
//   wrap_inc           : increment an index modulo n.
package vx_wb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int VX_NUM_THREADS = 4;
  localparam int VX_NW_BITS     = 2;
  localparam int VX_NR_BITS     = 6;

  typedef struct packed {
    logic [VX_NW_BITS-1:0]        wid;
    logic [31:0]                  pc;
    logic [VX_NUM_THREADS-1:0]    tmask;
    logic [VX_NR_BITS-1:0]        rd;
    logic [VX_NUM_THREADS*32-1:0] data;
    logic                         eop;
  } wb_payload_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter -- combinational single-grant selector.
//   req        in  NUM_REQS  request vector (already gated by the caller)
//   ptr        in  IDX_W     scan start index (ignored in fixed mode)
//   grant_oh   out NUM_REQS  one-hot grant, zero when nothing requested
//   grant_idx  out IDX_W     index of the granted request
//   grant_valid out 1        any grant issued
// ARB_MODE = ARB_FIXED scans from index 0; ARB_RR scans upward from ptr,
// wrapping modulo NUM_REQS.
module vx_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int ARB_MODE = 1,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_REQS-1:0] grant_oh,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);
  import vx_wb_pkg::*;

  int   base;
  int   idx;
  logic found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    base      = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = base + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!found && req[IDX_W'(idx)]) begin
        found                   = 1'b1;
        grant_oh[IDX_W'(idx)]   = 1'b1;
        grant_idx               = IDX_W'(idx);
      end
    end
    grant_valid = found;
  end

endmodule

// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter -- merges NUM_REQS commit channels onto one registered
// writeback port.
//   clk, reset (async, active-low)
//   commit_valid/commit_wb/commit_* in : per-channel commit + payload
//   commit_ready out                   : per-channel accept
//   wb_valid/wb_* out, wb_ready in     : registered writeback, latency 1
//   dbg_ptr out                        : round-robin pointer state
//   perf_stall_cycles out              : only with VX_WB_PERF_EN defined
// Handshake: a channel transfers on a cycle where it is requesting
// (commit_valid && commit_wb) and commit_ready is high; the writeback
// transfers when wb_valid && wb_ready. commit_ready never depends on the
// channel's own valid beyond masking idle channels to 1.
module vx_wb_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int ARB_MODE    = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQS-1:0]                    commit_valid,
  input  logic [NUM_REQS-1:0]                    commit_wb,
  input  logic [NUM_REQS-1:0][NW_BITS-1:0]       commit_wid,
  input  logic [NUM_REQS-1:0][31:0]              commit_PC,
  input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]   commit_tmask,
  input  logic [NUM_REQS-1:0][NR_BITS-1:0]       commit_rd,
  input  logic [NUM_REQS-1:0][NUM_THREADS*32-1:0] commit_data,
  input  logic [NUM_REQS-1:0]                    commit_eop,
  output logic [NUM_REQS-1:0]                    commit_ready,
  output logic                                   wb_valid,
  output logic [NW_BITS-1:0]                     wb_wid,
  output logic [31:0]                            wb_PC,
  output logic [NUM_THREADS-1:0]                 wb_tmask,
  output logic [NR_BITS-1:0]                     wb_rd,
  output logic [NUM_THREADS*32-1:0]              wb_data,
  output logic                                   wb_eop,
  input  logic                                   wb_ready,
  output logic [$clog2(NUM_REQS)-1:0]            dbg_ptr
`ifdef VX_WB_PERF_EN
  ,
  output logic [NUM_REQS-1:0][31:0]              perf_stall_cycles
`endif
);
  import vx_wb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0] requesting;
  logic [NUM_REQS-1:0] arb_req;
  logic [NUM_REQS-1:0] grant_oh;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                stall;

  logic                      wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [NW_BITS-1:0]        wid_q, wid_d;
  logic [31:0]               pc_q, pc_d;
  logic [NUM_THREADS-1:0]    tmask_q, tmask_d;
  logic [NR_BITS-1:0]        rd_q, rd_d;
  logic [NUM_THREADS*32-1:0] data_q, data_d;
  logic                      eop_q, eop_d;

  assign requesting = commit_valid & commit_wb;
  assign stall      = wb_valid_q & ~wb_ready;
  // A stalled output register cannot take a new payload, so no grant.
  assign arb_req    = stall ? '0 : requesting;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req         (arb_req),
    .ptr         (ptr_q),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Non-writing channels are always accepted; they never reach wb_*.
  assign commit_ready = ~requesting | grant_oh;

  always_comb begin
    wb_valid_d = wb_valid_q;
    ptr_d      = ptr_q;
    wid_d      = wid_q;
    pc_d       = pc_q;
    tmask_d    = tmask_q;
    rd_d       = rd_q;
    data_d     = data_q;
    eop_d      = eop_q;
    if (!stall) begin
      wb_valid_d = grant_valid;
      if (grant_valid) begin
        wid_d   = commit_wid[grant_idx];
        pc_d    = commit_PC[grant_idx];
        tmask_d = commit_tmask[grant_idx];
        rd_d    = commit_rd[grant_idx];
        data_d  = commit_data[grant_idx];
        eop_d   = commit_eop[grant_idx];
        if (ARB_MODE == ARB_RR) ptr_d = IDX_W'(wrap_inc(int'(grant_idx), NUM_REQS));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      ptr_q      <= ptr_d;
    end
  end

  // Payload is qualified by wb_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    wid_q   <= wid_d;
    pc_q    <= pc_d;
    tmask_q <= tmask_d;
    rd_q    <= rd_d;
    data_q  <= data_d;
    eop_q   <= eop_d;
  end

  assign wb_valid = wb_valid_q;
  assign wb_wid   = wid_q;
  assign wb_PC    = pc_q;
  assign wb_tmask = tmask_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_eop   = eop_q;
  assign dbg_ptr  = ptr_q;

`ifdef VX_WB_PERF_EN
  logic [NUM_REQS-1:0][31:0] perf_q, perf_d;

  // Counts cycles a writing channel is held off; wraps naturally at 2^32.
  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (requesting[i] && !commit_ready[i]) perf_d[i] = perf_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule
